rdmx_xfer_sched: RTL and testbench
==================================

RDMX_XFER_SCHED -- requirements
Module: rdmx_xfer_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning: request FIFO entries (power of 2, 2..16).
REQ-002 Parameter START_WAIT, default 16, meaning: cycles allowed for dma_idle to drop after dma_start.
REQ-003 Parameter DONE_WAIT, default 1048576, meaning: cycles allowed for a transfer to complete.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  permits new transfers to be issued.
REQ-007 req_addr  input  64  host source address of one 1 MiB block.
REQ-008 req_valid / req_ready  input / output  1  request handshake; transfer on valid&ready.
REQ-009 dma_src_address  output  64  source address to the DMA engine.
REQ-010 dma_start  output  1  one-cycle start pulse to the DMA engine.
REQ-011 dma_idle  input  1  DMA engine idle status.
REQ-012 busy  output  1  high in any state other than S_IDLE.
REQ-013 xfer_count  output  32  completed transfers, wraps at 2^32.
REQ-014 err_null / err_timeout  output  1  sticky error flags.
REQ-015 clear_err  input  1  clears both sticky flags.

Function
REQ-016 req_ready SHALL equal FIFO not full; a push and a pop in the same cycle on a full FIFO SHALL NOT raise req_ready in that cycle.
REQ-017 States: S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE.
REQ-018 S_IDLE: when enable & FIFO non-empty & dma_idle, pop one entry.
REQ-019 Popped address == 0 SHALL set err_null, be discarded, and leave the state at S_IDLE.
REQ-020 Popped nonzero address SHALL be latched into dma_src_address; next state S_START.
REQ-021 S_START: dma_start=1 for exactly one cycle (pop cycle N -> start at N+1); next S_WAIT_BUSY.
REQ-022 S_WAIT_BUSY: dma_idle=0 -> S_WAIT_DONE; START_WAIT cycles elapse with dma_idle=1 -> set err_timeout, S_IDLE, xfer_count unchanged.
REQ-023 S_WAIT_DONE: dma_idle=1 -> xfer_count+1, S_IDLE.
REQ-024 S_WAIT_DONE: after DONE_WAIT cycles, set err_timeout and remain in S_WAIT_DONE until dma_idle=1.
REQ-025 dma_src_address SHALL stay stable from S_START until the next latch.
REQ-026 Deassertion of enable SHALL NOT abort a transfer in progress; it only blocks further pops.
REQ-027 clear_err coincident with a new error event: the set SHALL win.
REQ-028 Cycle counters SHALL reset on every state entry and saturate at their limit.

Reset
REQ-029 On reset: state S_IDLE, FIFO empty, dma_start=0, dma_src_address=0, xfer_count=0, err_null=0, err_timeout=0, busy=0; req_ready=0 while reset is asserted.
REQ-030 After a mid-transfer reset, no pop SHALL occur until dma_idle=1 (per REQ-018).

Structure
REQ-031 Package rdmx_sched_pkg SHALL hold the state enum, the 1 MiB block-size constant, and default parameter values.
REQ-032 The request FIFO SHALL be the sub-module rdmx_addr_fifo (64-bit, FIFO_DEPTH, valid/ready on both sides).

Verification
REQ-033 Push 0x1000_0000 with enable=1 and a DMA model (idle drops 2 cycles after start, returns 100 cycles later) -> one dma_start with address 0x1000_0000; xfer_count=1; busy low afterwards.
REQ-034 Push 5 addresses back-to-back with FIFO_DEPTH=4 -> req_ready low after 4 pushes; all 5 issued in order; xfer_count=5.
REQ-035 Push address 0 -> err_null=1, no dma_start, xfer_count=0; clear_err -> err_null=0.
REQ-036 DMA model never drops idle -> err_timeout set 16 cycles after dma_start; return to S_IDLE; next queued request is issued.
REQ-037 Assert reset during S_WAIT_DONE with dma_idle held 0 for 50 more cycles -> all outputs reset; no pop until dma_idle=1.
REQ-038 enable=0 with 2 queued entries -> no dma_start; enable=1 -> both issued, one at a time.

Source files
------------

// File: rtl/rdmx_sched_pkg.sv
// Shared types and defaults for the RDMX transfer scheduler.
package rdmx_sched_pkg;

  localparam int unsigned BLOCK_BYTES    = 32'h0010_0000;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_START_WAIT = 16;
  localparam int unsigned DEF_DONE_WAIT  = 1048576;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rdmx_addr_fifo.sv
// Request address FIFO; ready reflects "not full" only, never the pop
// of the same cycle, and is held low while reset is asserted.
module rdmx_addr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, push, pop;

  assign full        = (count_q == FULL_CNT);
  assign in_ready_o  = ~full & ~reset;
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & ~full;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rdmx_xfer_sched.sv
// Issues queued 1 MiB block transfers to the DMA engine one at a time,
// with start/done watchdogs and sticky error flags.
//   state       | meaning
//   S_IDLE      | waiting for enable, a queued address and an idle engine
//   S_START     | dma_start pulse for the latched address
//   S_WAIT_BUSY | waiting for the engine to leave idle
//   S_WAIT_DONE | transfer running, waiting for idle again
module rdmx_xfer_sched
  import rdmx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned START_WAIT = DEF_START_WAIT,
  parameter int unsigned DONE_WAIT  = DEF_DONE_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] req_addr,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [63:0] dma_src_address,
  output logic        dma_start,
  input  logic        dma_idle,
  output logic        busy,
  output logic [31:0] xfer_count,
  output logic        err_null,
  output logic        err_timeout,
  input  logic        clear_err
);

  // The start cycle itself counts toward the start window.
  localparam logic [31:0] START_LOAD = 32'(START_WAIT - 1);
  localparam logic [31:0] DONE_LOAD  = 32'(DONE_WAIT);

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic        start_q, start_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] xfer_q, xfer_d;
  logic        enull_q, enull_d, eto_q, eto_d;
  logic        set_null, set_to;
  logic        fifo_valid, pop;
  logic [63:0] fifo_data;

  rdmx_addr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (req_valid),
    .in_ready_o  (req_ready),
    .in_data_i   (req_addr),
    .out_valid_o (fifo_valid),
    .out_ready_i (pop),
    .out_data_o  (fifo_data)
  );

  assign pop = (state_q == S_IDLE) & enable & fifo_valid & dma_idle;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    start_d  = 1'b0;
    cnt_d    = cnt_q;
    xfer_d   = xfer_q;
    set_null = 1'b0;
    set_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (fifo_data == '0) begin
            set_null = 1'b1;
          end else begin
            addr_d  = fifo_data;
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = START_LOAD;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!dma_idle) begin
          cnt_d   = DONE_LOAD;
          state_d = S_WAIT_DONE;
        end else if (cnt_q <= 32'd1) begin
          set_to  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WAIT_DONE: begin
        if (dma_idle) begin
          xfer_d  = xfer_q + 32'd1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          // Flag fires once as the count reaches zero, then saturates.
          cnt_d  = cnt_q - 32'd1;
          set_to = (cnt_q == 32'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    enull_d = (enull_q & ~clear_err) | set_null;
    eto_d   = (eto_q & ~clear_err) | set_to;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
      xfer_q  <= '0;
      enull_q <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
      enull_q <= enull_d;
      eto_q   <= eto_d;
    end
  end

  assign dma_src_address = addr_q;
  assign dma_start       = start_q;
  assign busy            = (state_q != S_IDLE);
  assign xfer_count      = xfer_q;
  assign err_null        = enull_q;
  assign err_timeout     = eto_q;

endmodule

// File: tb/tb_rdmx_xfer_sched.sv
// Scenario bench for rdmx_xfer_sched with a behavioural DMA engine model.
module tb_rdmx_xfer_sched;
  import rdmx_sched_pkg::*;

  localparam int START_WAIT = 16;
  localparam int DONE_WAIT  = 200;
  localparam int M_NORMAL = 0, M_NEVER = 1, M_HANG = 2;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, req_valid = 1'b0;
  logic        dma_idle = 1'b1, clear_err = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_ready, dma_start, busy, err_null, err_timeout;
  logic [63:0] dma_src_address;
  logic [31:0] xfer_count;

  rdmx_xfer_sched #(.FIFO_DEPTH(4), .START_WAIT(START_WAIT), .DONE_WAIT(DONE_WAIT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_addr(req_addr),
    .req_valid(req_valid), .req_ready(req_ready), .dma_src_address(dma_src_address),
    .dma_start(dma_start), .dma_idle(dma_idle), .busy(busy), .xfer_count(xfer_count),
    .err_null(err_null), .err_timeout(err_timeout), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int mode = M_NORMAL;
  bit hang_release = 1'b0;
  int drop_cnt = 0, busy_cnt = 0, n_start = 0, overlap = 0, start_cyc = 0, fall_cyc = 0;
  int exp_xfer = 0, push_cyc = 0;
  logic [63:0] started[$];
  logic [63:0] exp_q[$];

  // DMA engine: idle drops 2 cycles after a start, returns 100 cycles later.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (dma_start) begin
      started.push_back(dma_src_address);
      start_cyc = cyc;
      n_start++;
      if (drop_cnt != 0 || !dma_idle) overlap++;
      drop_cnt = 2;
    end else if (drop_cnt != 0) begin
      drop_cnt--;
      if (drop_cnt == 0 && mode != M_NEVER) begin
        dma_idle = 1'b0; busy_cnt = 100; fall_cyc = cyc;
      end
    end else if (!dma_idle) begin
      if (mode == M_NORMAL) begin
        busy_cnt--;
        if (busy_cnt == 0) dma_idle = 1'b1;
      end else if (mode == M_HANG && hang_release) begin
        dma_idle = 1'b1;
      end
    end
  end

  function automatic logic [63:0] rand_block();
    logic [63:0] a;
    a = {$urandom, $urandom} & ~64'(BLOCK_BYTES - 1);
    if (a == '0) a = 64'(BLOCK_BYTES);
    return a;
  endfunction

  task automatic push(input logic [63:0] a, output bit ok);
    ok = 1'b0; req_addr = a; req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (req_ready === 1'b1) begin @(posedge clk); ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    push_cyc = cyc; req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n_exp, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_start >= n_exp && !busy && dma_idle && drop_cnt == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (dma_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", dma_start); end
    checks++; if (dma_src_address !== 64'h0) begin errors++; $display("FAIL rst_addr got %h want 0", dma_src_address); end
    checks++; if (xfer_count !== 32'h0) begin errors++; $display("FAIL rst_xfer got %0d want 0", xfer_count); end
    checks++; if ({err_null, err_timeout} !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", {err_null, err_timeout}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    bit ok; int base; logic [63:0] a;
    started.delete(); base = n_start; enable = 1'b1; a = 64'h1000_0000;
    push(a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_push got timeout want accepted"); end
    wait_done(base + 1, 500, ok);
    exp_xfer++;
    checks++; if (!ok) begin errors++; $display("FAIL single_done got timeout want done"); end
    checks++; if (n_start - base !== 1) begin errors++; $display("FAIL single_nstart got %0d want 1", n_start - base); end
    checks++; if (started.size() < 1 || started[0] !== a) begin errors++; $display("FAIL single_addr got %h want %h", (started.size() > 0) ? started[0] : 64'hx, a); end
    checks++; if (start_cyc !== push_cyc + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", start_cyc - push_cyc, 1); end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL single_xfer got %0d want %0d", xfer_count, exp_xfer); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    checks++; if (dma_src_address !== a) begin errors++; $display("FAIL single_hold got %h want %h", dma_src_address, a); end
  endtask

  task automatic test_back_to_back();
    bit ok; int base; logic [63:0] a, got;
    started.delete(); exp_q.delete(); base = n_start; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = rand_block(); exp_q.push_back(a);
      push(a, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_push%0d got timeout want accepted", i); end
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", req_ready); end
    enable = 1'b1;
    a = rand_block(); exp_q.push_back(a);
    req_valid = 1'b1; req_addr = a;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_pop got %b want 0", req_ready); end
    push(a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_push4 got timeout want accepted"); end
    wait_done(base + 5, 2000, ok);
    exp_xfer += 5;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done got timeout want done"); end
    checks++; if (n_start - base !== 5) begin errors++; $display("FAIL b2b_nstart got %0d want 5", n_start - base); end
    foreach (exp_q[i]) begin
      got = (i < started.size()) ? started[i] : 64'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL b2b_order%0d got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL b2b_xfer got %0d want %0d", xfer_count, exp_xfer); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_null();
    bit ok; int base;
    base = n_start; enable = 1'b1;
    push(64'h0, ok);
    repeat (3) @(negedge clk);
    checks++; if (err_null !== 1'b1) begin errors++; $display("FAIL null_set got %b want 1", err_null); end
    checks++; if (n_start !== base) begin errors++; $display("FAIL null_nostart got %0d want %0d", n_start, base); end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL null_xfer got %0d want %0d", xfer_count, exp_xfer); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL null_busy got %b want 0", busy); end
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    checks++; if (err_null !== 1'b0) begin errors++; $display("FAIL null_clear got %b want 0", err_null); end
    push(64'h0, ok);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    checks++; if (err_null !== 1'b1) begin errors++; $display("FAIL null_setwins got %b want 1", err_null); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL null_noto got %b want 0", err_timeout); end
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
  endtask

  task automatic test_start_timeout();
    bit ok; int base, s, t; logic [63:0] a, b, got;
    mode = M_NEVER; started.delete(); exp_q.delete(); base = n_start; enable = 1'b0;
    a = rand_block(); b = rand_block(); exp_q.push_back(a); exp_q.push_back(b);
    push(a, ok); push(b, ok);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (n_start > base) begin ok = 1'b1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL sto_start got none want start"); end
    s = start_cyc; ok = 1'b0; t = 0;
    for (int i = 0; i < 100; i++) begin
      if (err_timeout === 1'b1) begin ok = 1'b1; t = cyc; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL sto_flag got 0 want 1"); end
    checks++; if (t !== s + START_WAIT) begin errors++; $display("FAIL sto_delay got %0d want %0d", t - s, START_WAIT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sto_idle got %b want 0", busy); end
    mode = M_NORMAL;
    wait_done(base + 2, 500, ok);
    exp_xfer++;
    checks++; if (!ok) begin errors++; $display("FAIL sto_next got timeout want done"); end
    foreach (exp_q[i]) begin
      got = (i < started.size()) ? started[i] : 64'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL sto_order%0d got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL sto_xfer got %0d want %0d", xfer_count, exp_xfer); end
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL sto_clear got %b want 0", err_timeout); end
  endtask

  task automatic test_enable_gate();
    bit ok; int base; logic [63:0] a, b, got;
    mode = M_NORMAL; started.delete(); exp_q.delete(); base = n_start; enable = 1'b0;
    a = rand_block(); b = rand_block(); exp_q.push_back(a); exp_q.push_back(b);
    push(a, ok); push(b, ok);
    repeat (30) @(negedge clk);
    checks++; if (n_start !== base) begin errors++; $display("FAIL en_gate got %0d starts want 0", n_start - base); end
    enable = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (n_start > base) begin ok = 1'b1; break; end end
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL en_first got none want start"); end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (!busy) begin ok = 1'b1; break; end end
    exp_xfer++;
    checks++; if (!ok) begin errors++; $display("FAIL en_noabort got busy want complete"); end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL en_xfer1 got %0d want %0d", xfer_count, exp_xfer); end
    repeat (20) @(negedge clk);
    checks++; if (n_start - base !== 1) begin errors++; $display("FAIL en_block got %0d starts want 1", n_start - base); end
    enable = 1'b1;
    wait_done(base + 2, 500, ok);
    exp_xfer++;
    checks++; if (!ok) begin errors++; $display("FAIL en_second got timeout want done"); end
    foreach (exp_q[i]) begin
      got = (i < started.size()) ? started[i] : 64'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL en_order%0d got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL en_xfer2 got %0d want %0d", xfer_count, exp_xfer); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL en_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_done_timeout();
    bit ok; int t;
    mode = M_HANG; hang_release = 1'b0; enable = 1'b1;
    push(rand_block(), ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin ok = 1'b1; t = cyc; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL dto_flag got 0 want 1"); end
    checks++; if (t !== fall_cyc + 1 + DONE_WAIT) begin errors++; $display("FAIL dto_delay got %0d want %0d", t - fall_cyc, 1 + DONE_WAIT); end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dto_stay got %b want 1", busy); end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL dto_xfer0 got %0d want %0d", xfer_count, exp_xfer); end
    hang_release = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (!busy) begin ok = 1'b1; break; end end
    exp_xfer++;
    checks++; if (!ok) begin errors++; $display("FAIL dto_finish got busy want idle"); end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL dto_xfer1 got %0d want %0d", xfer_count, exp_xfer); end
    hang_release = 1'b0; mode = M_NORMAL;
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int base; logic [63:0] a, b, c, got;
    mode = M_HANG; hang_release = 1'b0; enable = 1'b1;
    started.delete(); exp_q.delete(); base = n_start;
    a = rand_block(); b = rand_block(); c = rand_block();
    exp_q.push_back(a); exp_q.push_back(c);
    push(a, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (!dma_idle && busy) begin ok = 1'b1; break; end end
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_running got idle want busy"); end
    push(b, ok);
    reset = 1'b1; #1;
    exp_xfer = 0;
    checks++; if ({busy, dma_start, req_ready} !== 3'b000) begin errors++; $display("FAIL rmid_ctl got %b want 000", {busy, dma_start, req_ready}); end
    checks++; if (dma_src_address !== 64'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", dma_src_address); end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL rmid_xfer got %0d want %0d", xfer_count, exp_xfer); end
    checks++; if ({err_null, err_timeout} !== 2'b00) begin errors++; $display("FAIL rmid_err got %b want 00", {err_null, err_timeout}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(c, ok);
    repeat (50) @(negedge clk);
    checks++; if (n_start - base !== 1) begin errors++; $display("FAIL rmid_nopop got %0d starts want 1", n_start - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    hang_release = 1'b1;
    wait_done(base + 2, 200, ok);
    exp_xfer++;
    checks++; if (!ok) begin errors++; $display("FAIL rmid_resume got timeout want done"); end
    foreach (exp_q[i]) begin
      got = (i < started.size()) ? started[i] : 64'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rmid_order%0d got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (xfer_count !== 32'(exp_xfer)) begin errors++; $display("FAIL rmid_xfer1 got %0d want %0d", xfer_count, exp_xfer); end
    hang_release = 1'b0; mode = M_NORMAL;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_null();
    test_start_timeout();
    test_enable_gate();
    test_done_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
